me_result_sink: RTL and testbench

- Receiving end of the motion-estimation search output interface. Accepts `vector_me` and `img_mb` write requests from the search engine.
- Buffers each stream in its own small FIFO and applies backpressure through the `*_wait_fifo` signals.
- Drains both FIFOs to two linear memory regions through a single Avalon-MM write master, toward HPS-visible SDRAM.
- Sits between the search engine and the FPGA-to-SDRAM bridge.

---
 rtl/me_sink_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/me_result_sink.sv | 175 +++++++++++++++++
 tb/tb_me_result_sink.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_sink_pkg.sv
// Shared types and constants for the motion-estimation result sink.
// Word widths, the FSM state encoding and the address helper live here.
package me_sink_pkg;

  localparam int VEC_W       = 24;
  localparam int IMG_W       = 26;
  localparam int WORD_W      = 32;
  localparam int CNT_W       = 16;
  localparam int ADDR_STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef enum logic {
    STREAM_VEC = 1'b0,
    STREAM_IMG = 1'b1
  } stream_t;

  // Byte address of word number 'count' in a linear region; wraps at 32 bits.
  function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                  input logic [CNT_W-1:0]  count);
    return base + WORD_W'(count) * WORD_W'(ADDR_STRIDE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small show-ahead FIFO: rd_data always presents the oldest entry.
// Pushes while full are discarded; the caller is told via 'full'.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/me_result_sink.sv
// Buffers the vector and macroblock result streams and drains them, round-robin,
// through one Avalon-MM write master into two linear memory regions.
module me_result_sink
  import me_sink_pkg::*;
#(
  parameter int FIFO_AW   = 4,
  parameter int AF_MARGIN = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] vector_base,
  input  logic [WORD_W-1:0] img_base,
  input  logic [VEC_W-1:0]  vector_me,
  input  logic              vector_wr_req,
  output logic              vector_wait_fifo,
  input  logic [IMG_W-1:0]  img_mb,
  input  logic              img_wr_req,
  output logic              img_wait_fifo,
  output logic [WORD_W-1:0] avm_address,
  output logic              avm_write,
  output logic [WORD_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  output logic [CNT_W-1:0]  vector_words,
  output logic [CNT_W-1:0]  img_words,
  output logic [1:0]        overflow,
  output logic              idle
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] AF_LEVEL = (FIFO_AW+1)'(DEPTH - AF_MARGIN);

  logic [VEC_W-1:0]  vec_head;
  logic [IMG_W-1:0]  img_head;
  logic              vec_full, vec_empty, img_full, img_empty;
  logic [FIFO_AW:0]  vec_count, img_count;
  logic              vec_pop, img_pop;
  logic              pick_img, arb_go, start_ok;
  logic [1:0]        overflow_next;

  state_t            state_reg;
  stream_t           rr_reg;
  stream_t           served_reg;
  logic [WORD_W-1:0] avm_address_reg, avm_writedata_reg;
  logic              avm_write_reg;
  logic [WORD_W-1:0] vector_base_reg, img_base_reg;
  logic [CNT_W-1:0]  vector_words_reg, img_words_reg;
  logic [1:0]        overflow_reg;
  logic              vector_wait_reg, img_wait_reg, idle_reg;

  sync_fifo #(.WIDTH(VEC_W), .AW(FIFO_AW)) u_vec_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (vector_wr_req),
    .wr_data (vector_me),
    .pop     (vec_pop),
    .rd_data (vec_head),
    .full    (vec_full),
    .empty   (vec_empty),
    .count   (vec_count)
  );

  sync_fifo #(.WIDTH(IMG_W), .AW(FIFO_AW)) u_img_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (img_wr_req),
    .wr_data (img_mb),
    .pop     (img_pop),
    .rd_data (img_head),
    .full    (img_full),
    .empty   (img_empty),
    .count   (img_count)
  );

  // On a tie the round-robin pointer names the stream that was not served last.
  always_comb begin
    pick_img = 1'b0;
    if (!vec_empty && !img_empty) begin
      pick_img = (rr_reg == STREAM_IMG);
    end else begin
      pick_img = !img_empty;
    end
  end

  assign arb_go   = (state_reg == ARB) && !(vec_empty && img_empty);
  assign vec_pop  = arb_go && !pick_img;
  assign img_pop  = arb_go && pick_img;
  assign start_ok = start && idle_reg;

  always_comb begin
    overflow_next = start_ok ? 2'b00 : overflow_reg;
    overflow_next = overflow_next | {img_wr_req & img_full, vector_wr_req & vec_full};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      rr_reg            <= STREAM_VEC;
      served_reg        <= STREAM_VEC;
      avm_address_reg   <= '0;
      avm_writedata_reg <= '0;
      avm_write_reg     <= 1'b0;
      vector_base_reg   <= '0;
      img_base_reg      <= '0;
      vector_words_reg  <= '0;
      img_words_reg     <= '0;
      overflow_reg      <= '0;
      vector_wait_reg   <= 1'b0;
      img_wait_reg      <= 1'b0;
      idle_reg          <= 1'b1;
    end else begin
      overflow_reg    <= overflow_next;
      vector_wait_reg <= (vec_count >= AF_LEVEL);
      img_wait_reg    <= (img_count >= AF_LEVEL);
      idle_reg        <= (state_reg == IDLE) && vec_empty && img_empty &&
                         !vector_wr_req && !img_wr_req;

      if (start_ok) begin
        vector_base_reg  <= vector_base;
        img_base_reg     <= img_base;
        vector_words_reg <= '0;
        img_words_reg    <= '0;
      end

      case (state_reg)
        IDLE: begin
          // A strobe this cycle counts as pending so ARB follows immediately.
          if (!vec_empty || !img_empty || vector_wr_req || img_wr_req) begin
            state_reg <= ARB;
          end
        end
        ARB: begin
          if (arb_go) begin
            served_reg    <= pick_img ? STREAM_IMG : STREAM_VEC;
            rr_reg        <= pick_img ? STREAM_VEC : STREAM_IMG;
            avm_write_reg <= 1'b1;
            if (pick_img) begin
              avm_address_reg   <= word_addr(img_base_reg, img_words_reg);
              avm_writedata_reg <= {{(WORD_W-IMG_W){1'b0}}, img_head};
            end else begin
              avm_address_reg   <= word_addr(vector_base_reg, vector_words_reg);
              avm_writedata_reg <= {{(WORD_W-VEC_W){1'b0}}, vec_head};
            end
            state_reg <= WRITE;
          end else begin
            state_reg <= IDLE;
          end
        end
        WRITE: begin
          if (!avm_waitrequest) begin
            avm_write_reg <= 1'b0;
            state_reg     <= ARB;
            if (served_reg == STREAM_IMG) begin
              img_words_reg <= img_words_reg + CNT_W'(1);
            end else begin
              vector_words_reg <= vector_words_reg + CNT_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign avm_address      = avm_address_reg;
  assign avm_write        = avm_write_reg;
  assign avm_writedata    = avm_writedata_reg;
  assign vector_words     = vector_words_reg;
  assign img_words        = img_words_reg;
  assign overflow         = overflow_reg;
  assign vector_wait_fifo = vector_wait_reg;
  assign img_wait_fifo    = img_wait_reg;
  assign idle             = idle_reg;

endmodule

// File: tb/tb_me_result_sink.sv
// Scoreboard bench for me_result_sink: stimulus pushes expected words per stream,
// a negedge monitor scores every accepted Avalon write and every stalled cycle.
module tb_me_result_sink;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] vector_base = '0;
  logic [31:0] img_base = '0;
  logic [23:0] vector_me = '0;
  logic        vector_wr_req = 1'b0;
  logic        vector_wait_fifo;
  logic [25:0] img_mb = '0;
  logic        img_wr_req = 1'b0;
  logic        img_wait_fifo;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [15:0] vector_words;
  logic [15:0] img_words;
  logic [1:0]  overflow;
  logic        idle;

  me_result_sink #(.FIFO_AW(4), .AF_MARGIN(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .vector_base      (vector_base),
    .img_base         (img_base),
    .vector_me        (vector_me),
    .vector_wr_req    (vector_wr_req),
    .vector_wait_fifo (vector_wait_fifo),
    .img_mb           (img_mb),
    .img_wr_req       (img_wr_req),
    .img_wait_fifo    (img_wait_fifo),
    .avm_address      (avm_address),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_waitrequest  (avm_waitrequest),
    .vector_words     (vector_words),
    .img_words        (img_words),
    .overflow         (overflow),
    .idle             (idle)
  );

  always #5 clk = ~clk;

  // Reference model: expected words per stream, region bases and word counts.
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] vq[$];
  logic [31:0] iq[$];
  logic [31:0] m_vbase = '0, m_ibase = '0;
  int          m_vcnt = 0, m_icnt = 0;
  int          v_pushed = 0, i_pushed = 0;
  logic [1:0]  m_ovf = '0;
  logic        seq[$];
  logic        rand_wait = 1'b0;

  logic        stall_pending = 1'b0;
  logic [31:0] stall_addr, stall_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] region_addr(input logic [31:0] base, input int n);
    return base + 32'((n & 32'hFFFF) * 4);
  endfunction

  // Monitor: address/data held while stalled; each accepted write matches a stream head.
  always @(negedge clk) begin
    if (reset) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        vectors++;
        if (!(avm_write === 1'b1 && avm_address === stall_addr && avm_writedata === stall_data)) begin
          miscompares++;
          $display("FAIL stall_hold: write=%b addr=0x%08h data=0x%08h, required write=1 addr=0x%08h data=0x%08h",
                   avm_write, avm_address, avm_writedata, stall_addr, stall_data);
        end
      end
      stall_pending = avm_write && avm_waitrequest;
      stall_addr    = avm_address;
      stall_data    = avm_writedata;
      if (avm_write === 1'b1 && avm_waitrequest === 1'b0) begin
        vectors++;
        if (vq.size() > 0 && avm_address === region_addr(m_vbase, m_vcnt)) begin
          if (avm_writedata !== vq[0]) begin
            miscompares++;
            $display("FAIL vec_data: addr=0x%08h got 0x%08h, required 0x%08h", avm_address, avm_writedata, vq[0]);
          end
          void'(vq.pop_front());
          m_vcnt++;
          seq.push_back(1'b0);
        end else if (iq.size() > 0) begin
          if (avm_address !== region_addr(m_ibase, m_icnt) || avm_writedata !== iq[0]) begin
            miscompares++;
            $display("FAIL img_write: got addr=0x%08h data=0x%08h, required addr=0x%08h data=0x%08h",
                     avm_address, avm_writedata, region_addr(m_ibase, m_icnt), iq[0]);
          end
          void'(iq.pop_front());
          m_icnt++;
          seq.push_back(1'b1);
        end else begin
          miscompares++;
          if (vq.size() > 0)
            $display("FAIL vec_addr: got 0x%08h, required 0x%08h", avm_address, region_addr(m_vbase, m_vcnt));
          else
            $display("FAIL unexpected_write: addr=0x%08h data=0x%08h, required no write", avm_address, avm_writedata);
        end
      end
    end
  end

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input logic vreq, input logic [23:0] vd, input logic ireq, input logic [25:0] id);
    vector_wr_req = vreq; vector_me = vd;
    img_wr_req = ireq; img_mb = id;
    if (rand_wait) avm_waitrequest = ($urandom_range(0, 99) < 50);
    @(posedge clk); #1;
    vector_wr_req = 1'b0; img_wr_req = 1'b0;
  endtask

  task automatic push_model(input logic vreq, input logic [23:0] vd, input logic ireq, input logic [25:0] id);
    if (vreq) begin vq.push_back({8'h00, vd}); v_pushed++; end
    if (ireq) begin iq.push_back({6'b0, id}); i_pushed++; end
  endtask

  // Start only takes effect when nothing is outstanding in the model.
  task automatic do_start(input logic [31:0] vb, input logic [31:0] ib);
    start = 1'b1; vector_base = vb; img_base = ib;
    if (vq.size() == 0 && iq.size() == 0) begin
      m_vbase = vb; m_ibase = ib; m_vcnt = 0; m_icnt = 0;
      v_pushed = 0; i_pushed = 0; m_ovf = '0;
    end
    step(1'b0, '0, 1'b0, '0);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    step(1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    for (int c = 0; c < 600 && !done; c++) begin
      if (idle === 1'b1 && vq.size() == 0 && iq.size() == 0) done = 1'b1;
      else step(1'b0, '0, 1'b0, '0);
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: idle=%b pending vec=%0d img=%0d, required idle=1 with none pending",
               name, idle, vq.size(), iq.size());
    end
    avm_waitrequest = 1'b0;
  endtask

  // Producer that honours the wait flags, randomly strobing each stream.
  task automatic traffic(input int cycles, input int pct);
    logic vr, ir;
    logic [23:0] vd;
    logic [25:0] id;
    for (int c = 0; c < cycles; c++) begin
      vr = !vector_wait_fifo && ($urandom_range(0, 99) < pct);
      ir = !img_wait_fifo && ($urandom_range(0, 99) < pct);
      vd = 24'($urandom());
      id = 26'($urandom());
      push_model(vr, vd, ir, id);
      step(vr, vd, ir, id);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fill, prev_fill;
    logic [23:0] vd;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step(1'b0, '0, 1'b0, '0);
    check("rst_avm_write", 32'(avm_write), 32'd0);
    check("rst_avm_address", avm_address, 32'h0);
    check("rst_avm_writedata", avm_writedata, 32'h0);
    check("rst_wait", {30'd0, vector_wait_fifo, img_wait_fifo}, 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_counters", {vector_words, img_words}, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // 1: single vector word, latency and counter
    do_start(32'h1000_0000, 32'h2000_0000);
    push_model(1'b1, 24'hABCDEF, 1'b0, '0);
    step(1'b1, 24'hABCDEF, 1'b0, '0);
    check("lat_write_n1", 32'(avm_write), 32'd0);
    step(1'b0, '0, 1'b0, '0);
    check("lat_write_n2", 32'(avm_write), 32'd1);
    check("single_addr", avm_address, 32'h1000_0000);
    check("single_data", avm_writedata, 32'h00AB_CDEF);
    step(1'b0, '0, 1'b0, '0);
    check("single_count", 32'(vector_words), 32'(v_pushed));
    wait_idle("single");
    check("single_idle", 32'(idle), 32'd1);

    // 2: overfill the vector FIFO while an img write is stalled
    avm_waitrequest = 1'b1;
    push_model(1'b0, '0, 1'b1, 26'h3AB_CDEF);
    step(1'b0, '0, 1'b1, 26'h3AB_CDEF);
    repeat (3) step(1'b0, '0, 1'b0, '0);
    fill = 0; prev_fill = 0;
    for (int i = 0; i < 20; i++) begin
      check("burst_wait", 32'(vector_wait_fifo), 32'(prev_fill >= 13));
      prev_fill = fill;
      vd = 24'($urandom());
      if (fill < 16) begin push_model(1'b1, vd, 1'b0, '0); fill++; end
      else m_ovf[0] = 1'b1;
      step(1'b1, vd, 1'b0, '0);
    end
    check("burst_wait_end", 32'(vector_wait_fifo), 32'(prev_fill >= 13));
    check("burst_overflow", 32'(overflow), 32'(m_ovf));
    avm_waitrequest = 1'b0;
    wait_idle("burst");
    check("burst_vec_words", 32'(vector_words), 32'(v_pushed));
    check("burst_img_words", 32'(img_words), 32'(i_pushed));
    check("burst_overflow_sticky", 32'(overflow), 32'(m_ovf));

    // 3: both streams every cycle, zero waitrequest
    do_start(32'h1000_0000, 32'h2000_0000);
    check("start_clears_overflow", 32'(overflow), 32'(m_ovf));
    seq.delete();
    traffic(60, 100);
    wait_idle("dual");
    if (seq.size() >= 20) begin
      for (int k = 1; k < 20; k++) check("alternate", 32'(seq[k]), 32'(!seq[k-1]));
    end else begin
      check("dual_write_count", 32'(seq.size()), 32'd20);
    end
    check("dual_vec_words", 32'(vector_words), 32'(v_pushed));
    check("dual_img_words", 32'(img_words), 32'(i_pushed));
    check("dual_overflow", 32'(overflow), 32'(m_ovf));

    // 4: random waitrequest and random producer
    do_start(32'hFFFF_FFF0, 32'h0000_0100);
    rand_wait = 1'b1;
    traffic(200, 40);
    wait_idle("random");
    rand_wait = 1'b0;
    avm_waitrequest = 1'b0;
    check("rand_vec_words", 32'(vector_words), 32'(v_pushed));
    check("rand_img_words", 32'(img_words), 32'(i_pushed));
    check("rand_overflow", 32'(overflow), 32'(m_ovf));

    // 5: start while busy is ignored; start after drain rebases and clears
    avm_waitrequest = 1'b1;
    push_model(1'b1, 24'h123456, 1'b0, '0);
    step(1'b1, 24'h123456, 1'b0, '0);
    repeat (2) step(1'b0, '0, 1'b0, '0);
    do_start(32'h3000_0000, 32'h4000_0000);
    avm_waitrequest = 1'b0;
    wait_idle("busy_start");
    check("busy_start_count", 32'(vector_words), 32'(v_pushed));
    do_start(32'h3000_0000, 32'h4000_0000);
    step(1'b0, '0, 1'b0, '0);
    check("restart_counters", {vector_words, img_words}, {16'(v_pushed), 16'(i_pushed)});
    push_model(1'b1, 24'h000001, 1'b1, 26'h2000002);
    step(1'b1, 24'h000001, 1'b1, 26'h2000002);
    push_model(1'b1, 24'hFFFFFF, 1'b0, '0);
    step(1'b1, 24'hFFFFFF, 1'b0, '0);
    wait_idle("rebase");
    check("rebase_vec_words", 32'(vector_words), 32'(v_pushed));
    check("rebase_img_words", 32'(img_words), 32'(i_pushed));

    // 6: reset in the middle of a stalled write with 5 entries queued
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 24'(i + 16), 1'b0, '0);
    repeat (2) step(1'b0, '0, 1'b0, '0);
    reset = 1'b1;
    vq.delete(); iq.delete();
    m_vbase = '0; m_ibase = '0; m_vcnt = 0; m_icnt = 0;
    v_pushed = 0; i_pushed = 0; m_ovf = '0;
    step(1'b0, '0, 1'b0, '0);
    check("rst_mid_write", 32'(avm_write), 32'd0);
    check("rst_mid_idle", 32'(idle), 32'd1);
    check("rst_mid_counters", {vector_words, img_words}, 32'd0);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (10) step(1'b0, '0, 1'b0, '0);
    check("post_rst_idle", 32'(idle), 32'd1);
    check("post_rst_counters", {vector_words, img_words}, 32'd0);
    check("post_rst_overflow", 32'(overflow), 32'(m_ovf));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
